data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM with byte-lane stores, TX byte FIFO, STATUS and CYCLE registers
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int TX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  byteEnable,
    output logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
    localparam logic [31:0] CYCLE_ADDR  = 32'h1000_0008;
    localparam logic [3:0]  FULL_COUNT  = 4'(TX_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(TX_DEPTH - 1);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [3:0]    count;
    logic          overflow;
    logic [31:0]   cycle;

    logic          is_ram;
    logic          is_tx;
    logic          is_status;
    logic          is_cycle;
    logic [AW-1:0] idx;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic [31:0]   status;

    assign is_ram    = (a[31:28] == 4'h0);
    assign is_tx     = (a == TXDATA_ADDR);
    assign is_status = (a == STATUS_ADDR);
    assign is_cycle  = (a == CYCLE_ADDR);
    assign idx       = a[AW+1:2];

    // Store data is replicated across lanes so the lane mask alone selects placement.
    always_comb begin
        lane_en   = 4'b0000;
        lane_data = wd;
        case (byteEnable)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                lane_en   = byteEnable;
                lane_data = {4{wd[7:0]}};
            end
            4'b0011, 4'b1100: begin
                lane_en   = byteEnable;
                lane_data = {2{wd[15:0]}};
            end
            4'b1111: begin
                lane_en   = 4'b1111;
                lane_data = wd;
            end
            default: lane_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr && we && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) ram[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == 4'd0);
    assign tx_valid = !empty;
    assign tx_data  = fifo[rptr];
    assign push     = we && is_tx && byteEnable[0];
    assign pop      = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!clr && push_ok) fifo[wptr] <= wd[7:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
            cycle    <= 32'd0;
        end else begin
            cycle <= cycle + 32'd1;
            if (push_ok) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
            if (pop)     rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (we && is_status)
                overflow <= 1'b0;
            else if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign status = {24'd0, count, 1'b0, overflow, empty, full};

    always_comb begin
        rd = 32'd0;
        if (is_ram)
            rd = ram[idx];
        else if (is_status)
            rd = status;
        else if (is_cycle)
            rd = cycle;
    end

endmodule
